// File: rtl/unit_riesgos_idex_pkg.sv
// Shared definitions for the ID-stage hazard unit and ID/EX register.
package unit_riesgos_idex_pkg;

  // Default register index width and drain depth (pipeline stages behind ID).
  localparam int BITS_REGS_DEF    = 5;
  localparam int DRAIN_CYCLES_DEF = 4;

  // Pipeline control states.
  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_HALTED = 2'b10
  } state_e;

  // Bubble value for every control bit of the ID/EX register.
  localparam logic CTRL_BUBBLE = 1'b0;

  // Width needed to hold a count from 0 to n-1 (never narrower than 1 bit).
  function automatic int cnt_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/unit_riesgos_idex_hazard_compare.sv
// Combinational hazard detection: load-use against EX, and branch operands
// against the producers in EX and MEM. Register r0 never matches.
module unit_riesgos_idex_hazard_compare #(
  parameter int BITS_REGS = 5
) (
  input  logic [BITS_REGS-1:0] i_id_rs,
  input  logic [BITS_REGS-1:0] i_id_rt,
  input  logic                 i_id_uses_rt,
  input  logic                 i_id_branch,
  input  logic [BITS_REGS-1:0] i_ex_rd,
  input  logic                 i_ex_reg_write,
  input  logic                 i_ex_mem_read,
  input  logic [BITS_REGS-1:0] i_mem_rd,
  input  logic                 i_mem_mem_read,
  output logic                 o_load_use,
  output logic                 o_br_haz
);

  // A producer index "hits" a consumer index only when both match and the
  // producer is not r0 (writes to r0 are discarded, so nothing waits on them).
  function automatic logic hit(input logic [BITS_REGS-1:0] prod,
                               input logic [BITS_REGS-1:0] cons);
    return (prod != {BITS_REGS{1'b0}}) && (prod == cons);
  endfunction

  logic ex_hit_rs_s;
  logic ex_hit_rt_s;
  logic mem_hit_s;

  // Operand match decode and the two hazard terms.
  always_comb begin
    ex_hit_rs_s = hit(i_ex_rd, i_id_rs);
    ex_hit_rt_s = hit(i_ex_rd, i_id_rt);
    mem_hit_s   = hit(i_mem_rd, i_id_rs) | hit(i_mem_rd, i_id_rt);

    o_load_use  = i_ex_mem_read & (ex_hit_rs_s | (i_id_uses_rt & ex_hit_rt_s));

    // The branch compares in ID, so it needs both operands: an ALU result
    // still in EX, or a load still in MEM, forces a wait.
    o_br_haz    = i_id_branch &
                  ((i_ex_reg_write & (ex_hit_rs_s | ex_hit_rt_s)) |
                   (i_mem_mem_read & mem_hit_s));
  end

endmodule

// File: rtl/unit_riesgos_idex.sv
// ID-stage hazard control and ID/EX pipeline register. Stalls PC and IF/ID,
// injects bubbles into ID/EX, flushes IF/ID on taken branches and drains the
// pipeline when a HALT leaves ID.
module unit_riesgos_idex
  import unit_riesgos_idex_pkg::*;
#(
  parameter int BITS_REGS    = BITS_REGS_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic [BITS_REGS-1:0] i_id_rs,
  input  logic [BITS_REGS-1:0] i_id_rt,
  input  logic [BITS_REGS-1:0] i_id_rd,
  input  logic                 i_id_uses_rt,
  input  logic                 i_id_reg_write,
  input  logic                 i_id_mem_read,
  input  logic                 i_id_branch,
  input  logic                 i_branch_taken,
  input  logic                 i_id_halt,
  input  logic [BITS_REGS-1:0] i_mem_rd,
  input  logic                 i_mem_mem_read,
  input  logic                 i_resume,
  output logic                 o_pc_write,
  output logic                 o_ifid_write,
  output logic                 o_ifid_flush,
  output logic [BITS_REGS-1:0] o_ex_rs,
  output logic [BITS_REGS-1:0] o_ex_rt,
  output logic [BITS_REGS-1:0] o_ex_rd,
  output logic                 o_ex_reg_write,
  output logic                 o_ex_mem_read,
  output logic                 o_halted
);

  localparam int               CNT_W    = cnt_width(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [BITS_REGS-1:0] REG_ZERO = {BITS_REGS{1'b0}};

  // ID/EX register contents.
  logic [BITS_REGS-1:0] ex_rs_q, ex_rs_d;
  logic [BITS_REGS-1:0] ex_rt_q, ex_rt_d;
  logic [BITS_REGS-1:0] ex_rd_q, ex_rd_d;
  logic                 ex_reg_write_q, ex_reg_write_d;
  logic                 ex_mem_read_q, ex_mem_read_d;

  // Control state and drain countdown.
  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 load_use_s;
  logic                 br_haz_s;
  logic                 stall_s;

  unit_riesgos_idex_hazard_compare #(
    .BITS_REGS (BITS_REGS)
  ) u_hazard_compare (
    .i_id_rs        (i_id_rs),
    .i_id_rt        (i_id_rt),
    .i_id_uses_rt   (i_id_uses_rt),
    .i_id_branch    (i_id_branch),
    .i_ex_rd        (ex_rd_q),
    .i_ex_reg_write (ex_reg_write_q),
    .i_ex_mem_read  (ex_mem_read_q),
    .i_mem_rd       (i_mem_rd),
    .i_mem_mem_read (i_mem_mem_read),
    .o_load_use     (load_use_s),
    .o_br_haz       (br_haz_s)
  );

  // Hazards only matter while instructions are actually flowing.
  assign stall_s = (state_q == ST_RUN) & (load_use_s | br_haz_s);

  // Next-state: FSM transitions, drain countdown and ID/EX capture or bubble.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    ex_rs_d        = REG_ZERO;
    ex_rt_d        = REG_ZERO;
    ex_rd_d        = REG_ZERO;
    ex_reg_write_d = CTRL_BUBBLE;
    ex_mem_read_d  = CTRL_BUBBLE;
    case (state_q)
      ST_RUN: begin
        if (stall_s) begin
          // Bubble only; a HALT in ID waits here until the stall clears.
          state_d = ST_RUN;
        end else if (i_id_halt) begin
          // HALT itself enters ID/EX as a bubble.
          state_d = ST_DRAIN;
          cnt_d   = CNT_LOAD;
        end else begin
          ex_rs_d        = i_id_rs;
          ex_rt_d        = i_id_rt;
          ex_rd_d        = i_id_rd;
          ex_reg_write_d = i_id_reg_write;
          ex_mem_read_d  = i_id_mem_read;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = ST_HALTED;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_HALTED: begin
        if (i_resume) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_HALTED;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // State registers; i_enable low freezes everything.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q        <= ST_RUN;
      cnt_q          <= CNT_ZERO;
      ex_rs_q        <= REG_ZERO;
      ex_rt_q        <= REG_ZERO;
      ex_rd_q        <= REG_ZERO;
      ex_reg_write_q <= 1'b0;
      ex_mem_read_q  <= 1'b0;
    end else if (i_enable) begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      ex_rs_q        <= ex_rs_d;
      ex_rt_q        <= ex_rt_d;
      ex_rd_q        <= ex_rd_d;
      ex_reg_write_q <= ex_reg_write_d;
      ex_mem_read_q  <= ex_mem_read_d;
    end
  end

  // Front-end control decode from the current state and hazard status.
  always_comb begin
    o_pc_write   = 1'b0;
    o_ifid_write = 1'b0;
    o_ifid_flush = 1'b0;
    o_halted     = 1'b0;
    case (state_q)
      ST_RUN: begin
        o_pc_write   = ~stall_s;
        o_ifid_write = ~stall_s;
        // Stall wins: the branch re-resolves once its operands are ready.
        o_ifid_flush = i_branch_taken & ~stall_s;
      end
      ST_DRAIN: begin
        o_halted = 1'b0;
      end
      ST_HALTED: begin
        o_halted = 1'b1;
      end
      default: begin
        o_halted = 1'b0;
      end
    endcase
  end

  assign o_ex_rs        = ex_rs_q;
  assign o_ex_rt        = ex_rt_q;
  assign o_ex_rd        = ex_rd_q;
  assign o_ex_reg_write = ex_reg_write_q;
  assign o_ex_mem_read  = ex_mem_read_q;

endmodule

// File: tb/tb_unit_riesgos_idex.sv
// Scoreboard bench for unit_riesgos_idex: each stimulus cycle queues the
// expected outputs; a monitor on the falling edge pops and compares.
module tb_unit_riesgos_idex;

  logic       clk;
  logic       rst;
  logic       en;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       id_uses_rt, id_rw, id_mr, id_br, br_taken, id_halt;
  logic [4:0] mem_rd;
  logic       mem_mr, resume;

  logic       pc_write, ifid_write, ifid_flush, halted;
  logic [4:0] ex_rs, ex_rt, ex_rd;
  logic       ex_rw, ex_mr;

  typedef struct {
    string       name;
    logic [20:0] val;   // {pc_w, ifid_w, flush, halted, rs, rt, rd, rw, mr}
  } exp_t;

  exp_t        sb_q[$];
  exp_t        cur;
  logic [20:0] act;
  int          checks   = 0;
  int          failures = 0;

  unit_riesgos_idex #(
    .BITS_REGS    (5),
    .DRAIN_CYCLES (4)
  ) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_enable       (en),
    .i_id_rs        (id_rs),
    .i_id_rt        (id_rt),
    .i_id_rd        (id_rd),
    .i_id_uses_rt   (id_uses_rt),
    .i_id_reg_write (id_rw),
    .i_id_mem_read  (id_mr),
    .i_id_branch    (id_br),
    .i_branch_taken (br_taken),
    .i_id_halt      (id_halt),
    .i_mem_rd       (mem_rd),
    .i_mem_mem_read (mem_mr),
    .i_resume       (resume),
    .o_pc_write     (pc_write),
    .o_ifid_write   (ifid_write),
    .o_ifid_flush   (ifid_flush),
    .o_ex_rs        (ex_rs),
    .o_ex_rt        (ex_rt),
    .o_ex_rd        (ex_rd),
    .o_ex_reg_write (ex_rw),
    .o_ex_mem_read  (ex_mr),
    .o_halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: drive inputs just after the rising edge, queue what the
  // outputs must show at the following falling edge.
  task automatic cyc(input string nm, input logic r, input logic e,
                     input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                     input logic ur, input logic rw, input logic mr,
                     input logic br, input logic tk, input logic hl,
                     input logic [4:0] mrd, input logic mmr, input logic rsm,
                     input logic [3:0] ctl,
                     input logic [4:0] ers, input logic [4:0] ert, input logic [4:0] erd,
                     input logic erw, input logic emr);
    exp_t x;
    @(posedge clk);
    #1;
    rst = r; en = e;
    id_rs = rs; id_rt = rt; id_rd = rd;
    id_uses_rt = ur; id_rw = rw; id_mr = mr;
    id_br = br; br_taken = tk; id_halt = hl;
    mem_rd = mrd; mem_mr = mmr; resume = rsm;
    x.name = nm;
    x.val  = {ctl, ers, ert, erd, erw, emr};
    sb_q.push_back(x);
  endtask

  // Monitor: compare whatever the DUT presents against the queued expectation.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      cur = sb_q.pop_front();
      act = {pc_write, ifid_write, ifid_flush, halted, ex_rs, ex_rt, ex_rd, ex_rw, ex_mr};
      checks = checks + 1;
      if (act !== cur.val) begin
        failures = failures + 1;
        $display("FAIL %s: got pw=%b iw=%b fl=%b h=%b ex=%0d/%0d/%0d rw=%b mr=%b, expected pw=%b iw=%b fl=%b h=%b ex=%0d/%0d/%0d rw=%b mr=%b",
                 cur.name, act[20], act[19], act[18], act[17], act[16:12], act[11:7], act[6:2], act[1], act[0],
                 cur.val[20], cur.val[19], cur.val[18], cur.val[17], cur.val[16:12], cur.val[11:7],
                 cur.val[6:2], cur.val[1], cur.val[0]);
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b1;
    id_rs = '0; id_rt = '0; id_rd = '0;
    id_uses_rt = 1'b0; id_rw = 1'b0; id_mr = 1'b0;
    id_br = 1'b0; br_taken = 1'b0; id_halt = 1'b0;
    mem_rd = '0; mem_mr = 1'b0; resume = 1'b0;

    //   name            rst en  rs rt rd ur rw mr br tk hl mrd mmr rsm  ctl      ers ert erd erw emr
    cyc("reset",          1, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0,  4'b1100, 0,  0,  0,  0,  0);
    // load-use: lw r8 then add r9=r8+r1
    cyc("lw_r8_id",       0, 1,  4, 8, 8, 0, 1, 1, 0, 0, 0, 0,  0,  0,  4'b1100, 0,  0,  0,  0,  0);
    cyc("ldu_stall",      0, 1,  8, 1, 9, 1, 1, 0, 0, 0, 0, 0,  0,  0,  4'b0000, 4,  8,  8,  1,  1);
    cyc("ldu_bubble",     0, 1,  8, 1, 9, 1, 1, 0, 0, 0, 0, 0,  0,  0,  4'b1100, 0,  0,  0,  0,  0);
    // lw r8 then beq r8,r2: two stall cycles, flush on the third
    cyc("add_captured",   0, 1,  4, 8, 8, 0, 1, 1, 0, 0, 0, 0,  0,  0,  4'b1100, 8,  1,  9,  1,  0);
    cyc("beq_ld_ex",      0, 1,  8, 2, 0, 1, 0, 0, 1, 1, 0, 9,  0,  0,  4'b0000, 4,  8,  8,  1,  1);
    cyc("beq_ld_mem",     0, 1,  8, 2, 0, 1, 0, 0, 1, 1, 0, 8,  1,  0,  4'b0000, 0,  0,  0,  0,  0);
    cyc("beq_ld_flush",   0, 1,  8, 2, 0, 1, 0, 0, 1, 1, 0, 0,  0,  0,  4'b1110, 0,  0,  0,  0,  0);
    // add r5 then beq r5,r0 taken: one stall then flush
    cyc("add_r5_id",      0, 1,  1, 2, 5, 1, 1, 0, 0, 0, 0, 0,  0,  0,  4'b1100, 8,  2,  0,  0,  0);
    cyc("beq_alu_stall",  0, 1,  5, 0, 0, 1, 0, 0, 1, 1, 0, 0,  0,  0,  4'b0000, 1,  2,  5,  1,  0);
    cyc("beq_alu_flush",  0, 1,  5, 0, 0, 1, 0, 0, 1, 1, 0, 5,  0,  0,  4'b1110, 0,  0,  0,  0,  0);
    // load to r0 then use of r0: no stall
    cyc("lw_r0_id",       0, 1,  4, 0, 0, 0, 1, 1, 0, 0, 0, 0,  0,  0,  4'b1100, 5,  0,  0,  0,  0);
    cyc("r0_no_stall",    0, 1,  0, 0, 3, 1, 1, 0, 0, 0, 0, 0,  0,  0,  4'b1100, 4,  0,  0,  1,  1);
    // HALT: four DRAIN cycles, HALTED on the fifth
    cyc("halt_in_id",     0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0,  0,  4'b1100, 0,  0,  3,  1,  0);
    cyc("drain_1",        0, 1,  7, 7, 7, 1, 1, 0, 0, 0, 0, 0,  0,  0,  4'b0000, 0,  0,  0,  0,  0);
    cyc("drain_2",        0, 1,  7, 7, 7, 1, 1, 0, 0, 0, 0, 0,  0,  0,  4'b0000, 0,  0,  0,  0,  0);
    cyc("drain_3",        0, 1,  7, 7, 7, 1, 1, 0, 0, 0, 0, 0,  0,  0,  4'b0000, 0,  0,  0,  0,  0);
    cyc("drain_4",        0, 1,  7, 7, 7, 1, 1, 0, 0, 0, 0, 0,  0,  0,  4'b0000, 0,  0,  0,  0,  0);
    // resume while frozen has no effect; enabled resume returns to RUN
    cyc("halted_frozen",  0, 0,  7, 7, 7, 1, 1, 0, 0, 0, 0, 0,  0,  1,  4'b0001, 0,  0,  0,  0,  0);
    cyc("halted_resume",  0, 1,  7, 7, 7, 1, 1, 0, 0, 0, 0, 0,  0,  1,  4'b0001, 0,  0,  0,  0,  0);
    cyc("run_again",      0, 1,  7, 7, 7, 1, 1, 0, 0, 0, 0, 0,  0,  0,  4'b1100, 0,  0,  0,  0,  0);
    cyc("run_capture",    0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0,  4'b1100, 7,  7,  7,  1,  0);
    // i_enable low blocks the ID/EX capture
    cyc("enable_low",     0, 0,  1, 2, 3, 1, 1, 1, 0, 0, 0, 0,  0,  0,  4'b1100, 0,  0,  0,  0,  0);
    cyc("enable_hold",    0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0,  4'b1100, 0,  0,  0,  0,  0);
    // reset in the middle of DRAIN acts without a clock edge
    cyc("halt_again",     0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0,  0,  4'b1100, 0,  0,  0,  0,  0);
    cyc("drain_again",    0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0,  4'b0000, 0,  0,  0,  0,  0);
    cyc("reset_in_drain", 1, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0,  4'b1100, 0,  0,  0,  0,  0);
    cyc("after_reset",    0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0,  4'b1100, 0,  0,  0,  0,  0);

    // Let the monitor drain the scoreboard, with a bounded wait.
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
      @(posedge clk);
    end
    if (sb_q.size() > 0) begin
      failures = failures + 1;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
